// File: rtl/mem_arb_pkg.sv
// Shared types for the BRAM port arbiter: loader FSM states, grant select,
// and the width helper for the writer burst counter.
package mem_arb_pkg;

    // Loader handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } wr_state_e;

    // Which requester owns the memory port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_sel_e;

    // Bits needed to count 0..max_burst inclusive
    function automatic int burst_cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/load_handshake.sv
// JTAG loader side: four-phase word_r/ack handshake, captured byte,
// auto-incrementing write pointer and sticky wrap flag.
module load_handshake
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_en_i,
    input  logic              word_r_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              wr_gnt_i,
    output logic              wr_req_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              ack_o,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic              overflow_o
);

    wr_state_e         state_q, state_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic              load_en_q, load_en_d;

    // Loader FSM next state, pointer/overflow bookkeeping and data capture
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        ovf_d     = ovf_q;
        load_en_d = load_en_i;

        // A new session starts from address 0 with a clean wrap flag
        if (load_en_i && !load_en_q) begin
            ptr_d = '0;
            ovf_d = 1'b0;
        end

        // Every granted write advances the pointer; passing the top wraps
        if (wr_gnt_i) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == {ADDR_W{1'b1}}) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (load_en_i && word_r_i && !ack_q) begin
                    data_d  = word_i;
                    state_d = PEND;
                end
            end
            PEND: begin
                // A granted write always completes; only a live session acks it
                if (wr_gnt_i) begin
                    state_d = load_en_i ? ACK : IDLE;
                    ack_d   = load_en_i;
                end else if (!load_en_i) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!load_en_i || !word_r_i) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            data_q    <= '0;
            ptr_q     <= '0;
            ovf_q     <= 1'b0;
            load_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
            load_en_q <= load_en_d;
        end
    end

    // A pending byte is only offered while the session is still open
    assign wr_req_o   = (state_q == PEND) && load_en_i;
    assign wr_data_o  = data_q;
    assign ack_o      = ack_q;
    assign wr_ptr_o   = ptr_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/mem_load_arbiter.sv
// Single BRAM port shared between the JTAG loader (writer, priority) and a
// read requester; a burst counter bounds how long a pending read can wait.
module mem_load_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 8,
    parameter int MAX_WR_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_en_i,
    input  logic              word_r_i,
    input  logic [DATA_W-1:0] word_i,
    output logic              ack_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic              overflow_o
);

    localparam int                 BURST_W   = burst_cnt_width(MAX_WR_BURST);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_WR_BURST);

    logic              wr_req;
    logic              wr_gnt;
    logic              rd_gnt;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_ptr;
    gnt_sel_e          gnt_sel;

    logic [BURST_W-1:0] burst_q, burst_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    load_handshake #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_load_handshake (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_en_i  (load_en_i),
        .word_r_i   (word_r_i),
        .word_i     (word_i),
        .wr_gnt_i   (wr_gnt),
        .wr_req_o   (wr_req),
        .wr_data_o  (wr_data),
        .ack_o      (ack_o),
        .wr_ptr_o   (wr_ptr),
        .overflow_o (overflow_o)
    );

    // Pick the port owner: writer first, unless it has used up its burst
    always_comb begin
        gnt_sel = GNT_NONE;
        if (!rst_ni) begin
            gnt_sel = GNT_NONE;
        end else if (wr_req && rd_req_i) begin
            gnt_sel = (burst_q == BURST_MAX) ? GNT_RD : GNT_WR;
        end else if (wr_req) begin
            gnt_sel = GNT_WR;
        end else if (rd_req_i) begin
            gnt_sel = GNT_RD;
        end
    end

    // Drive the BRAM port from the selected requester; park on wr_ptr
    always_comb begin
        mem_addr_o  = wr_ptr;
        mem_we_o    = 1'b0;
        mem_wdata_o = wr_data;
        wr_gnt      = 1'b0;
        rd_gnt      = 1'b0;
        case (gnt_sel)
            GNT_WR: begin
                mem_we_o = 1'b1;
                wr_gnt   = 1'b1;
            end
            GNT_RD: begin
                mem_addr_o = rd_addr_i;
                rd_gnt     = 1'b1;
            end
            default: begin
                mem_we_o = 1'b0;
            end
        endcase
        if (!rst_ni) begin
            mem_addr_o = '0;
        end
    end

    // Count writer wins against a waiting reader; any read win or idle reader clears
    always_comb begin
        burst_d = burst_q;
        if (!rd_req_i || rd_gnt) begin
            burst_d = '0;
        end else if (wr_gnt && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    // Read return: valid one cycle after grant; data holds the last returned word
    always_comb begin
        rd_valid_d = rd_gnt;
        rd_data_d  = rd_valid_q ? mem_rdata_i : rd_data_q;
    end

    // Arbiter and read-return registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            burst_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            burst_q    <= burst_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_gnt_o   = rd_gnt;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_valid_q ? mem_rdata_i : rd_data_q;
    assign wr_ptr_o   = wr_ptr;

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Randomized self-checking bench for mem_load_arbiter. A BRAM lives in the
// bench; expected memory contents, pointer and wrap flag are kept as plain
// arrays/integers updated per completed loader word.
module tb_mem_load_arbiter;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 8;
    localparam int MAX_WR_BURST = 4;
    localparam int DEPTH        = 1 << ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              load_en_i;
    logic              word_r_i;
    logic [DATA_W-1:0] word_i;
    logic              ack_o;
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_gnt_o;
    logic              rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [ADDR_W-1:0] wr_ptr_o;
    logic              overflow_o;

    always #5 clk_i = ~clk_i;

    mem_load_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_WR_BURST (MAX_WR_BURST)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_en_i   (load_en_i),
        .word_r_i    (word_r_i),
        .word_i      (word_i),
        .ack_o       (ack_o),
        .rd_req_i    (rd_req_i),
        .rd_addr_i   (rd_addr_i),
        .rd_gnt_o    (rd_gnt_o),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .wr_ptr_o    (wr_ptr_o),
        .overflow_o  (overflow_o)
    );

    // Bench-side BRAM with registered read
    logic [DATA_W-1:0] bram [DEPTH];
    always @(posedge clk_i) begin
        if (mem_we_o) bram[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= bram[mem_addr_o];
    end

    // Reference model state
    logic [DATA_W-1:0] exp_mem [DEPTH];
    int                exp_ptr   = 0;
    bit                exp_ovf   = 1'b0;
    logic [DATA_W-1:0] cur_byte  = '0;
    int                words_sent = 0;
    int                writes_seen = 0;
    int                acks_seen  = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-cycle protocol monitor
    bit                mon_en   = 1'b0;
    bit                prev_gnt = 1'b0;
    logic [DATA_W-1:0] prev_exp = '0;
    logic              prev_ack = 1'b0;
    int                deny_run = 0;

    always @(negedge clk_i) begin
        if (!mon_en) begin
            prev_gnt = 1'b0;
            deny_run = 0;
            prev_ack = ack_o;
        end else begin
            if (prev_gnt) begin
                check("rd_valid", 32'(rd_valid_o), 1);
                check("rd_data", 32'(rd_data_o), 32'(prev_exp));
            end else begin
                check("rd_valid_idle", 32'(rd_valid_o), 0);
            end
            check("one_op", 32'(mem_we_o && rd_gnt_o), 0);
            if (rd_gnt_o) begin
                check("gnt_has_req", 32'(rd_req_i), 1);
                check("rd_port_addr", 32'(mem_addr_o), 32'(rd_addr_i));
            end
            if (mem_we_o) begin
                check("wr_addr", 32'(mem_addr_o), 32'(exp_ptr));
                check("wr_data", 32'(mem_wdata_o), 32'(cur_byte));
                writes_seen++;
            end
            if (!mem_we_o && !rd_gnt_o) begin
                check("idle_addr", 32'(mem_addr_o), 32'(wr_ptr_o));
            end
            if (rd_req_i && !rd_gnt_o) begin
                check("rd_lost_to_wr", 32'(mem_we_o), 1);
                deny_run++;
                if (deny_run > MAX_WR_BURST) check("starve_run", 32'(deny_run), 32'(MAX_WR_BURST));
            end else begin
                deny_run = 0;
            end
            if (ack_o && !prev_ack) acks_seen++;
            prev_ack = ack_o;
            prev_gnt = rd_gnt_o;
            prev_exp = exp_mem[rd_addr_i];
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full four-phase loader word, then model update
    task automatic send_byte(input logic [DATA_W-1:0] b);
        int n;
        cur_byte = b;
        word_i   = b;
        word_r_i = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ack_o && n < 40);
        check("ack_rise", 32'(ack_o), 1);
        word_r_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (ack_o && n < 40);
        check("ack_fall", 32'(ack_o), 0);
        exp_mem[exp_ptr] = b;
        if (exp_ptr == DEPTH - 1) exp_ovf = 1'b1;
        exp_ptr = (exp_ptr + 1) % DEPTH;
        words_sent++;
        check("wr_ptr", 32'(wr_ptr_o), 32'(exp_ptr));
        check("overflow", 32'(overflow_o), 32'(exp_ovf));
    endtask

    // Single read; returned data is checked by the monitor
    task automatic read_word(input int addr);
        int n;
        rd_addr_i = ADDR_W'(addr);
        rd_req_i  = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!rd_gnt_o && n < 20) begin @(negedge clk_i); n++; end
        check("rd_gnt_wait", 32'(rd_gnt_o), 1);
        tick();
        rd_req_i = 1'b0;
    endtask

    logic [DATA_W-1:0] first3 [3];

    initial begin
        first3[0] = 8'hA5; first3[1] = 8'h3C; first3[2] = 8'h7E;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]    = '0;
            exp_mem[i] = '0;
        end
        rst_ni = 1'b0; load_en_i = 1'b0; word_r_i = 1'b0; word_i = '0;
        rd_req_i = 1'b0; rd_addr_i = '0;
        repeat (3) tick();
        check("rst_ack", 32'(ack_o), 0);
        check("rst_ptr", 32'(wr_ptr_o), 0);
        check("rst_ovf", 32'(overflow_o), 0);
        check("rst_rd_valid", 32'(rd_valid_o), 0);
        check("rst_rd_data", 32'(rd_data_o), 0);
        check("rst_we", 32'(mem_we_o), 0);
        rst_ni = 1'b1;
        load_en_i = 1'b1;
        tick();
        mon_en = 1'b1;

        // Three loader words
        for (int i = 0; i < 3; i++) send_byte(first3[i]);
        for (int i = 0; i < 3; i++) check("bram_first3", 32'(bram[i]), 32'(first3[i]));
        check("acks_first3", 32'(acks_seen), 3);

        // Back-to-back reads of 0,1,2
        rd_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr_i = ADDR_W'(i);
            @(negedge clk_i);
            check("b2b_gnt", 32'(rd_gnt_o), 1);
            if (i > 0) check("b2b_data", 32'(rd_data_o), 32'(first3[i-1]));
            tick();
        end
        rd_req_i = 1'b0;
        @(negedge clk_i);
        check("b2b_data", 32'(rd_data_o), 32'(first3[2]));
        tick();

        // Loader stream against a continuously requesting reader
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    send_byte(DATA_W'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                rd_req_i = 1'b1;
                for (int k = 0; k < 30; k++) begin
                    int n;
                    rd_addr_i = ADDR_W'($urandom_range(0, 2));
                    n = 0;
                    @(negedge clk_i);
                    while (!rd_gnt_o && n < 20) begin @(negedge clk_i); n++; end
                    check("stream_gnt", 32'(rd_gnt_o), 1);
                    tick();
                end
                rd_req_i = 1'b0;
            end
        join
        tick();
        for (int a = 0; a < 43; a++) read_word(a);
        tick();
        check("writes_eq_words", 32'(writes_seen), 32'(words_sent));
        check("acks_eq_words", 32'(acks_seen), 32'(words_sent));

        // New session, full wrap plus one
        load_en_i = 1'b0;
        tick();
        check("ptr_hold_off", 32'(wr_ptr_o), 32'(exp_ptr));
        load_en_i = 1'b1;
        tick();
        exp_ptr = 0; exp_ovf = 1'b0;
        check("ptr_clear", 32'(wr_ptr_o), 0);
        for (int i = 0; i < DEPTH; i++) send_byte(DATA_W'(i));
        check("ovf_after_1024", 32'(overflow_o), 1);
        send_byte(8'hFF);
        check("ptr_after_wrap", 32'(wr_ptr_o), 1);
        read_word(0);
        @(negedge clk_i);
        check("bram0_ff", 32'(rd_data_o), 'hFF);
        tick();
        load_en_i = 1'b0;
        tick();
        check("ovf_hold_off", 32'(overflow_o), 1);
        check("ptr_hold_wrap", 32'(wr_ptr_o), 1);
        load_en_i = 1'b1;
        tick();
        exp_ptr = 0; exp_ovf = 1'b0;
        check("ovf_clear", 32'(overflow_o), 0);
        check("ptr_clear2", 32'(wr_ptr_o), 0);

        // Session dropped while a byte is pending
        begin
            int wb;
            wb = writes_seen;
            cur_byte = 8'h55; word_i = 8'h55; word_r_i = 1'b1;
            tick();
            load_en_i = 1'b0;
            tick();
            word_r_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check("drop_ack", 32'(ack_o), 0);
                tick();
            end
            check("drop_no_write", 32'(writes_seen), 32'(wb));
            check("drop_ptr", 32'(wr_ptr_o), 0);
        end
        load_en_i = 1'b1;
        tick();
        send_byte(8'h66);
        read_word(0);
        @(negedge clk_i);
        check("bram0_66", 32'(rd_data_o), 'h66);
        tick();

        // Reset with the writer in ACK and a read in flight
        cur_byte = 8'h11;
        word_i = 8'h11; word_r_i = 1'b1;
        begin
            int n;
            n = 0;
            do begin tick(); n++; end while (!ack_o && n < 40);
            check("pre_rst_ack", 32'(ack_o), 1);
        end
        exp_mem[exp_ptr] = 8'h11;
        mon_en = 1'b0;
        rd_addr_i = '0; rd_req_i = 1'b1;
        @(negedge clk_i);
        check("pre_rst_gnt", 32'(rd_gnt_o), 1);
        tick();
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("inrst_gnt", 32'(rd_gnt_o), 0);
        check("inrst_we", 32'(mem_we_o), 0);
        check("inrst_addr", 32'(mem_addr_o), 0);
        tick();
        check("postrst_valid", 32'(rd_valid_o), 0);
        check("postrst_ack", 32'(ack_o), 0);
        check("postrst_ptr", 32'(wr_ptr_o), 0);
        check("postrst_ovf", 32'(overflow_o), 0);
        check("postrst_data", 32'(rd_data_o), 0);
        rd_req_i = 1'b0; word_r_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        exp_ptr = 0; exp_ovf = 1'b0;
        mon_en = 1'b1;
        send_byte(DATA_W'($urandom_range(0, 255)));
        read_word(0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
